// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types. The branch predictor adds its index hash
// selection here. Its metadata struct depends on the predictor's
// parameterised widths, so it is declared inside bp_meta_pipe instead.
package rv32i_types;

  // Ways of combining the PC slice with global history to form the table index.
  typedef enum logic {
    BP_HASH_CONCAT = 1'b0,
    BP_HASH_XOR    = 1'b1
  } bp_hash_e;

endpackage

// File: rtl/bp_meta_pipe.sv
// Carries per-prediction metadata {valid, idx, ctr, pred} from fetch lookup to
// the resolve point in execute. Stages hold while stalled. Flush clears
// every valid bit and takes priority over stall.
module bp_meta_pipe #(
  parameter int DEPTH = 2,
  parameter int IDX_W = 9,
  parameter int CTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [IDX_W-1:0] in_idx,
  input  logic [CTR_W-1:0] in_ctr,
  input  logic             in_pred,
  output logic             tail_valid,
  output logic [IDX_W-1:0] tail_idx,
  output logic [CTR_W-1:0] tail_ctr,
  output logic             tail_pred
);

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
    logic [CTR_W-1:0] ctr;
    logic             pred;
  } bp_meta_t;

  bp_meta_t stage_q [DEPTH];
  bp_meta_t in_meta;

  assign in_meta = {in_valid, in_idx, in_ctr, in_pred};

  // Shift register: reset, then flush, then stall-hold, else advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i].valid <= 1'b0;
    end else if (!stall) begin
      stage_q[0] <= in_meta;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign tail_valid = stage_q[DEPTH-1].valid;
  assign tail_idx   = stage_q[DEPTH-1].idx;
  assign tail_ctr   = stage_q[DEPTH-1].ctr;
  assign tail_pred  = stage_q[DEPTH-1].pred;

endmodule

// File: rtl/gshare_predictor.sv
// Global-history branch direction predictor. Fetch reads a saturating counter
// combinationally. The counter value and index travel to execute, where the
// resolved direction updates the table, the non-speculative history and the
// branch/mispredict statistics.
module gshare_predictor
  import rv32i_types::*;
#(
  parameter int       PC_IDX_BITS = 5,
  parameter int       PC_LSB      = 2,
  parameter int       HIST_BITS   = 4,
  parameter int       CTR_BITS    = 2,
  parameter int       PIPE_DEPTH  = 2,
  parameter bp_hash_e HASH_MODE   = BP_HASH_CONCAT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_stall,
  input  logic        flush,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_pc,
  output logic        pred_taken,
  input  logic        resolve_valid,
  input  logic        resolve_taken,
  output logic        mispredict,
  output logic [31:0] br_count,
  output logic [31:0] mispred_count
);

  localparam int IDX_W   = (HASH_MODE == BP_HASH_CONCAT) ? (PC_IDX_BITS + HIST_BITS) : PC_IDX_BITS;
  localparam int ENTRIES = 1 << IDX_W;
  localparam logic [CTR_BITS-1:0] CTR_INIT = {1'b0, {(CTR_BITS-1){1'b1}}};
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;

  logic [CTR_BITS-1:0]    table_q [ENTRIES];
  logic [HIST_BITS-1:0]   ghr_q;
  logic [HIST_BITS-1:0]   ghr_shift;
  logic [PC_IDX_BITS-1:0] pc_slice;
  logic [IDX_W-1:0]       lookup_idx;
  logic [CTR_BITS-1:0]    lookup_ctr;
  logic                   pred_raw;
  logic                   tail_valid;
  logic [IDX_W-1:0]       tail_idx;
  logic [CTR_BITS-1:0]    tail_ctr;
  logic                   tail_pred;
  logic [CTR_BITS-1:0]    upd_ctr;
  logic                   accept;
  logic                   mispredict_raw;
  logic                   bypass_hit;
  logic                   unused_fetch_pc;

  // Only a slice of the PC feeds the index; the rest is intentionally ignored.
  assign unused_fetch_pc = ^fetch_pc;
  assign pc_slice        = fetch_pc[PC_LSB +: PC_IDX_BITS];

  // Index hash selected at elaboration time.
  generate
    if (HASH_MODE == BP_HASH_CONCAT) begin : g_concat
      assign lookup_idx = {pc_slice, ghr_q};
    end else begin : g_xor
      assign lookup_idx = pc_slice ^ IDX_W'(ghr_q);
    end
  endgenerate

  // History shift; a single-bit history simply takes the latest outcome.
  generate
    if (HIST_BITS == 1) begin : g_hist1
      assign ghr_shift = resolve_taken;
    end else begin : g_histn
      assign ghr_shift = {ghr_q[HIST_BITS-2:0], resolve_taken};
    end
  endgenerate

  bp_meta_pipe #(
    .DEPTH (PIPE_DEPTH),
    .IDX_W (IDX_W),
    .CTR_W (CTR_BITS)
  ) u_meta_pipe (
    .clk        (clk),
    .rst        (rst),
    .stall      (mem_stall),
    .flush      (flush),
    .in_valid   (fetch_valid),
    .in_idx     (lookup_idx),
    .in_ctr     (lookup_ctr),
    .in_pred    (pred_raw),
    .tail_valid (tail_valid),
    .tail_idx   (tail_idx),
    .tail_ctr   (tail_ctr),
    .tail_pred  (tail_pred)
  );

  // The update works from the counter value carried with the prediction.
  always_comb begin
    upd_ctr = tail_ctr;
    if (resolve_taken) begin
      if (tail_ctr != CTR_MAX) upd_ctr = tail_ctr + CTR_BITS'(1);
    end else begin
      if (tail_ctr != '0) upd_ctr = tail_ctr - CTR_BITS'(1);
    end
  end

  assign mispredict_raw = resolve_valid && tail_valid && (tail_pred != resolve_taken);
  assign accept         = !rst && resolve_valid && !mem_stall && tail_valid;
  assign mispredict     = !rst && mispredict_raw;

  // A same-cycle write to the looked-up entry is forwarded so fetch sees it.
  assign bypass_hit = accept && (tail_idx == lookup_idx);
  assign lookup_ctr = bypass_hit ? upd_ctr : table_q[lookup_idx];
  assign pred_raw   = lookup_ctr[CTR_BITS-1];
  assign pred_taken = !rst && pred_raw;

  // Counter table: reset to weakly not-taken, written on accepted resolves.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) table_q[i] <= CTR_INIT;
    end else if (accept) begin
      table_q[tail_idx] <= upd_ctr;
    end
  end

  // Non-speculative global history and resolve statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      ghr_q         <= '0;
      br_count      <= '0;
      mispred_count <= '0;
    end else if (accept) begin
      ghr_q    <= ghr_shift;
      br_count <= br_count + 32'd1;
      if (mispredict_raw) mispred_count <= mispred_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_gshare_predictor.sv
// Directed bench for gshare_predictor: one default (concat) instance and one
// XOR-hash instance. Expected values are queued as stimulus is driven and
// popped at each comparison point.
module tb_gshare_predictor;
  import rv32i_types::*;

  logic        clk;
  logic        rst;

  logic        a_mem_stall, a_flush, a_fetch_valid, a_resolve_valid, a_resolve_taken;
  logic [31:0] a_fetch_pc;
  logic        a_pred, a_mis;
  logic [31:0] a_br, a_misc;

  logic        b_mem_stall, b_flush, b_fetch_valid, b_resolve_valid, b_resolve_taken;
  logic [31:0] b_fetch_pc;
  logic        b_pred, b_mis;
  logic [31:0] b_br, b_misc;

  logic [31:0] exp_q[$];
  int          checks;
  int          failures;

  gshare_predictor u_dut_concat (
    .clk           (clk),
    .rst           (rst),
    .mem_stall     (a_mem_stall),
    .flush         (a_flush),
    .fetch_valid   (a_fetch_valid),
    .fetch_pc      (a_fetch_pc),
    .pred_taken    (a_pred),
    .resolve_valid (a_resolve_valid),
    .resolve_taken (a_resolve_taken),
    .mispredict    (a_mis),
    .br_count      (a_br),
    .mispred_count (a_misc)
  );

  gshare_predictor #(.HASH_MODE(BP_HASH_XOR)) u_dut_xor (
    .clk           (clk),
    .rst           (rst),
    .mem_stall     (b_mem_stall),
    .flush         (b_flush),
    .fetch_valid   (b_fetch_valid),
    .fetch_pc      (b_fetch_pc),
    .pred_taken    (b_pred),
    .resolve_valid (b_resolve_valid),
    .resolve_taken (b_resolve_taken),
    .mispredict    (b_mis),
    .br_count      (b_br),
    .mispred_count (b_misc)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fetch(input int inst, input logic fv, input logic [31:0] pc);
    if (inst == 0) begin
      a_fetch_valid = fv;
      a_fetch_pc    = pc;
    end else begin
      b_fetch_valid = fv;
      b_fetch_pc    = pc;
    end
  endtask

  task automatic set_resolve(input int inst, input logic rv, input logic rt);
    if (inst == 0) begin
      a_resolve_valid = rv;
      a_resolve_taken = rt;
    end else begin
      b_resolve_valid = rv;
      b_resolve_taken = rt;
    end
  endtask

  function automatic logic get_pred(input int inst);
    return (inst == 0) ? a_pred : b_pred;
  endfunction

  function automatic logic get_mis(input int inst);
    return (inst == 0) ? a_mis : b_mis;
  endfunction

  // Scoreboard
  task automatic expect_val(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $error("FAIL %s observed=%0h expected=<empty queue>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, e);
      end
    end
  endtask

  // Fetch one branch, let it reach the tail, then resolve it.
  task automatic run_branch(input int inst, input logic [31:0] pc, input logic taken,
                            input logic exp_pred, input logic exp_mis, input string tag);
    set_fetch(inst, 1'b1, pc);
    expect_val({31'd0, exp_pred});
    #2 check($sformatf("%s_pred", tag), {31'd0, get_pred(inst)});
    step();
    set_fetch(inst, 1'b0, pc);
    step();
    set_resolve(inst, 1'b1, taken);
    expect_val({31'd0, exp_mis});
    #2 check($sformatf("%s_mis", tag), {31'd0, get_mis(inst)});
    step();
    set_resolve(inst, 1'b0, 1'b0);
  endtask

  logic [31:0] cat_pc    [9];
  logic        cat_taken [9];
  logic        cat_pred  [9];
  logic        cat_mis   [9];

  // Directed sequence
  initial begin
    checks   = 0;
    failures = 0;
    cat_pc    = '{32'h100, 32'h100, 32'h100, 32'h100, 32'h18, 32'h100, 32'h100, 32'h100, 32'h100};
    cat_taken = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    cat_pred  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    cat_mis   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

    rst = 1'b1;
    a_mem_stall = 1'b0; a_flush = 1'b0;
    a_fetch_valid = 1'b1; a_fetch_pc = 32'h40;
    a_resolve_valid = 1'b1; a_resolve_taken = 1'b1;
    b_mem_stall = 1'b0; b_flush = 1'b0;
    b_fetch_valid = 1'b0; b_fetch_pc = 32'h0;
    b_resolve_valid = 1'b0; b_resolve_taken = 1'b0;

    // Reset cycle: outputs quiet, statistics cleared.
    repeat (2) @(posedge clk);
    #3;
    expect_val(32'd0); check("rst_pred", {31'd0, a_pred});
    expect_val(32'd0); check("rst_mis", {31'd0, a_mis});
    expect_val(32'd0); check("rst_br", a_br);
    expect_val(32'd0); check("rst_misc", a_misc);
    step();
    rst = 1'b0;
    a_fetch_valid = 1'b0; a_resolve_valid = 1'b0; a_resolve_taken = 1'b0;

    // Fresh entry for 0x40 reads weakly not-taken.
    expect_val(32'd0);
    #2 check("lookup_0x40", {31'd0, a_pred});

    // Four taken branches at 0x100 drive the history to 4'b1111.
    for (int k = 0; k < 4; k++)
      run_branch(0, 32'h100, 1'b1, 1'b0, 1'b1, $sformatf("warm%0d", k));

    // With history pinned at all-ones, train 0x40 taken: 01->10->11->11.
    run_branch(0, 32'h40, 1'b1, 1'b0, 1'b1, "train0");
    run_branch(0, 32'h40, 1'b1, 1'b1, 1'b0, "train1");
    run_branch(0, 32'h40, 1'b1, 1'b1, 1'b0, "train2");
    expect_val(32'd7); check("train_br", a_br);
    expect_val(32'd5); check("train_misc", a_misc);
    run_branch(0, 32'h40, 1'b1, 1'b1, 1'b0, "train_sat");

    // Flush squashes the in-flight prediction; the resolve is ignored.
    set_fetch(0, 1'b1, 32'h40);
    step();
    set_fetch(0, 1'b0, 32'h40);
    a_flush = 1'b1;
    step();
    a_flush = 1'b0;
    set_resolve(0, 1'b1, 1'b0);
    expect_val(32'd0);
    #2 check("flush_mis", {31'd0, a_mis});
    step();
    set_resolve(0, 1'b0, 1'b0);
    expect_val(32'd8); expect_val(32'd5);
    #2 check("flush_br", a_br);
    check("flush_misc", a_misc);

    // Stall with a mispredicting tail: flag held, counted once on release.
    set_fetch(0, 1'b1, 32'h40);
    expect_val(32'd1);
    #2 check("stall_pred", {31'd0, a_pred});
    step();
    set_fetch(0, 1'b0, 32'h40);
    step();
    set_resolve(0, 1'b1, 1'b0);
    a_mem_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      expect_val(32'd1); expect_val(32'd5); expect_val(32'd8);
      #2 check($sformatf("stall%0d_mis", k), {31'd0, a_mis});
      check($sformatf("stall%0d_misc", k), a_misc);
      check($sformatf("stall%0d_br", k), a_br);
      step();
    end
    a_mem_stall = 1'b0;
    expect_val(32'd1);
    #2 check("release_mis", {31'd0, a_mis});
    step();
    set_resolve(0, 1'b0, 1'b0);
    expect_val(32'd6); expect_val(32'd9);
    #2 check("release_misc", a_misc);
    check("release_br", a_br);

    // Same-cycle update and lookup of one entry: fetch sees the new counter.
    set_fetch(0, 1'b1, 32'h40);
    expect_val(32'd0);
    #2 check("byp_first_pred", {31'd0, a_pred});
    step();
    set_fetch(0, 1'b0, 32'h40);
    step();
    set_resolve(0, 1'b1, 1'b1);
    set_fetch(0, 1'b1, 32'h40);
    expect_val(32'd1); expect_val(32'd1);
    #2 check("byp_pred", {31'd0, a_pred});
    check("byp_mis", {31'd0, a_mis});
    step();
    set_resolve(0, 1'b0, 1'b0);
    set_fetch(0, 1'b0, 32'h40);
    step();
    expect_val(32'd10); expect_val(32'd7);
    #2 check("byp_br", a_br);
    check("byp_misc", a_misc);

    // Concat index: bring history to 0101, train 0x18, restore 0101, read back.
    for (int k = 0; k < 9; k++)
      run_branch(0, cat_pc[k], cat_taken[k], cat_pred[k], cat_mis[k], $sformatf("cat%0d", k));
    set_fetch(0, 1'b1, 32'h18);
    expect_val(32'd1);
    #2 check("cat_readback", {31'd0, a_pred});
    step();
    set_fetch(0, 1'b0, 32'h0);
    expect_val(32'd19); expect_val(32'd10);
    #2 check("cat_br", a_br);
    check("cat_misc", a_misc);

    // XOR index: history 0101 with slice 00110 writes entry 00011.
    run_branch(1, 32'h0, 1'b0, 1'b0, 1'b0, "xor_h0");
    run_branch(1, 32'h0, 1'b1, 1'b0, 1'b1, "xor_h1");
    run_branch(1, 32'h0, 1'b0, 1'b0, 1'b0, "xor_h2");
    run_branch(1, 32'h0, 1'b1, 1'b0, 1'b1, "xor_h3");
    run_branch(1, 32'h18, 1'b1, 1'b0, 1'b1, "xor_wr");
    // History is now 1011; slice 01000 maps back onto entry 00011.
    set_fetch(1, 1'b1, 32'h20);
    expect_val(32'd1);
    #2 check("xor_alias_pred", {31'd0, b_pred});
    set_fetch(1, 1'b1, 32'h18);
    expect_val(32'd0);
    #2 check("xor_other_pred", {31'd0, b_pred});
    step();
    set_fetch(1, 1'b0, 32'h0);
    expect_val(32'd5); expect_val(32'd3);
    #2 check("xor_br", b_br);
    check("xor_misc", b_misc);

    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL leftover_expectations observed=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
